// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters, with round-robin grant and a one-entry response slot.
// Define ALU_SHARE_FIXED_PRIO_EN to build with fixed priority, where req0 always wins over req1.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_zero
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  logic   slot_free;
  logic   grant0;
  logic   grant1;
  logic   accept;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic   last_grant;
`endif

  assign rsp_valid  = (state == FULL);
  assign slot_free  = (state == EMPTY) || rsp_ready;
  assign accept     = grant0 || grant1;
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // Grant select; reset suppresses every grant so no requester sees ready.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (slot_free && !reset) begin
      if (req0_valid && req1_valid) begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
        grant0 = 1'b1;
`else
        if (last_grant) begin
          grant0 = 1'b1;
        end else begin
          grant1 = 1'b1;
        end
`endif
      end else if (req0_valid) begin
        grant0 = 1'b1;
      end else if (req1_valid) begin
        grant1 = 1'b1;
      end else begin
        grant0 = 1'b0;
        grant1 = 1'b0;
      end
    end else begin
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  // Operand/opcode steering to the shared ALU; idle drives zeros.
  always_comb begin
    alu_a  = {DATA_W{1'b0}};
    alu_b  = {DATA_W{1'b0}};
    alu_op = {OP_W{1'b0}};
    case ({grant1, grant0})
      2'b01: begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
      2'b10: begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end
      default: begin
        alu_a  = {DATA_W{1'b0}};
        alu_b  = {DATA_W{1'b0}};
        alu_op = {OP_W{1'b0}};
      end
    endcase
  end

  // Response slot FSM: capture on accept, empty on drain without refill.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      rsp_id     <= 1'b0;
      rsp_result <= {DATA_W{1'b0}};
      rsp_zero   <= 1'b0;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant <= 1'b1;
`endif
    end else if (accept) begin
      state      <= FULL;
      rsp_id     <= grant1;
      rsp_result <= alu_result;
      rsp_zero   <= alu_zero;
`ifndef ALU_SHARE_FIXED_PRIO_EN
      last_grant <= grant1;
`endif
    end else begin
      case (state)
        FULL:    state <= rsp_ready ? EMPTY : FULL;
        EMPTY:   state <= EMPTY;
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters: req0 is the main EX-stage issue path and req1 is a secondary unit, e.g. the branch-compare or address-calc unit.
- Round-robin grant, one request accepted per cycle.
- Drives the shared ALU's operand and opcode inputs, registers the ALU result and zero flag, and returns them through a one-entry response slot with a valid/ready handshake and requester ID.
- Sits between the ID/EX pipeline register and the ALU instance inside the EX stage.

Parameters:
DATA_W, 32, operand/result width
OP_W, 3, ALU opcode width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 accepted this cycle
req0_op  in  OP_W  ALU opcode for requester 0
req0_a  in  DATA_W  operand A for requester 0
req0_b  in  DATA_W  operand B for requester 0
req1_valid  in  1  requester 1 has an operation
req1_ready  out  1  requester 1 accepted this cycle
req1_op  in  OP_W  ALU opcode for requester 1
req1_a  in  DATA_W  operand A for requester 1
req1_b  in  DATA_W  operand B for requester 1
alu_a  out  DATA_W  to shared ALU operand a
alu_b  out  DATA_W  to shared ALU operand b
alu_op  out  OP_W  to shared ALU opcode
alu_result  in  DATA_W  from shared ALU
alu_zero  in  1  from shared ALU
rsp_valid  out  1  response slot full
rsp_ready  in  1  consumer takes response
rsp_id  out  1  requester that issued the response (0/1)
rsp_result  out  DATA_W  registered ALU result
rsp_zero  out  1  registered ALU zero flag

Behaviour:
- Slot free condition: slot_free = !rsp_valid || rsp_ready. Drain and refill in the same cycle is allowed, giving full throughput of 1 op/cycle.
- Grant rules:
  - Combinational, only when slot_free.
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant register updates only on an accepted request.
- Ready: reqN_ready = grantN. It is never asserted when slot_free=0 or reqN_valid=0, and at most one ready is high per cycle.
- ALU drive: alu_a/alu_b/alu_op = the granted requester's fields. When there is no grant, they are driven to 0 (op 000). The ALU is combinational, so the block adds no extra wait.
- Capture on accept (rising edge): rsp_result<=alu_result, rsp_zero<=alu_zero, rsp_id<=granted index, rsp_valid<=1.
  - Latency: request accepted in cycle N gives rsp_valid in cycle N+1.
- Drain: rsp_valid && rsp_ready with no new accept gives rsp_valid<=0. rsp_result, rsp_zero and rsp_id hold their last values.
- Backpressure: while rsp_valid && !rsp_ready, the response outputs are stable and no ready is asserted.
- Requester rule: a requester must hold valid and its fields stable until ready. The block does not check this.
- Opcodes are forwarded opaquely; no decode, no width change.
- Reset (sync):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0.
  - last_grant=1, so req0 wins the first contention.
  - All ready outputs 0 while reset is high.
  - Reset mid-operation discards any pending response without a handshake.
- State machine (2 states):
  - EMPTY (rsp_valid=0): accept → FULL.
  - FULL: rsp_ready&&accept → FULL; rsp_ready&&!accept → EMPTY; !rsp_ready → FULL.

Optional Feature:
- Macro ALU_SHARE_FIXED_PRIO_EN.
- Defined: fixed priority. req0 always wins when both are valid, and the last_grant register is not implemented.
- Undefined (default): round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Single op: reset, then req0 op=000 a=5 b=7, rsp_ready=1 → req0_ready high in cycle N; cycle N+1 has rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0.
- Zero flag: req1 op=001 a=9 b=9 → rsp_id=1, rsp_result=0, rsp_zero=1.
- Contention, round-robin: both valid for 4 cycles, rsp_ready=1 → grants 0,1,0,1 and one response per cycle. With ALU_SHARE_FIXED_PRIO_EN defined → grants 0,0,0,0 and req1_ready never asserted.
- Backpressure: rsp_ready=0 while the response is held, req0 valid → both readys 0 and rsp_* stable for 3 cycles. Raise rsp_ready → same-cycle drain plus accept, new response the next cycle.
- Reset mid-operation: rsp_valid=1, assert reset one cycle → next cycle rsp_valid=0, rsp_result=0. First contention after reset is granted to req0.
- Idle: no valids → alu_a=0, alu_b=0, alu_op=000, rsp_valid drops after drain.
